// File: rtl/alu_pkg.sv
// Shared ALUConf operation codes, FSM state encoding and small helpers for alu_muldiv.
package alu_pkg;

    localparam int unsigned CONF_W = 5;

    localparam logic [CONF_W-1:0] ALU_ADD  = 5'b00000;
    localparam logic [CONF_W-1:0] ALU_OR   = 5'b00001;
    localparam logic [CONF_W-1:0] ALU_AND  = 5'b00010;
    localparam logic [CONF_W-1:0] ALU_ANDN = 5'b00011;
    localparam logic [CONF_W-1:0] ALU_SUB  = 5'b00110;
    localparam logic [CONF_W-1:0] ALU_SLT  = 5'b00111;
    localparam logic [CONF_W-1:0] ALU_NOR  = 5'b01100;
    localparam logic [CONF_W-1:0] ALU_XOR  = 5'b01101;
    localparam logic [CONF_W-1:0] ALU_SRL  = 5'b10000;
    localparam logic [CONF_W-1:0] ALU_SRA  = 5'b11000;
    localparam logic [CONF_W-1:0] ALU_SLL  = 5'b11001;
    localparam logic [CONF_W-1:0] ALU_MFHI = 5'b10110;
    localparam logic [CONF_W-1:0] ALU_MFLO = 5'b10111;
    localparam logic [CONF_W-1:0] ALU_MULT = 5'b10100;
    localparam logic [CONF_W-1:0] ALU_DIV  = 5'b10101;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CALC = 2'd1;
    localparam state_t ST_FIX  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    // Multi-cycle operations go through CALC/FIX instead of completing at once.
    function automatic logic is_iter_op(input logic [CONF_W-1:0] conf);
        return (conf == ALU_MULT) || (conf == ALU_DIV);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes,
// one bit per step over a shared adder, with combinational sign correction of the result.
module muldiv_iter import alu_pkg::*; #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last_c,
    output logic [WIDTH-1:0] fix_hi_c,
    output logic [WIDTH-1:0] fix_lo_c
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0]   hi_q, lo_q, opnd_q, a_raw_q;
    logic [CNT_W-1:0]   count_q;
    logic               is_div_q, neg_q, rem_neg_q, div_zero_q;

    logic [WIDTH-1:0]   a_mag_c, b_mag_c;
    logic [WIDTH:0]     add_a_c, add_b_c;
    logic [WIDTH+1:0]   sum_c;
    logic               no_borrow_c;
    logic [WIDTH-1:0]   hi_nxt_c, lo_nxt_c;
    logic [2*WIDTH-1:0] prod_c;

    assign a_mag_c = (sign && a[WIDTH-1]) ? -a : a;
    assign b_mag_c = (sign && b[WIDTH-1]) ? -b : b;

    // Multiply adds the multiplicand into HI; divide subtracts the divisor from {HI, next dividend bit}.
    always_comb begin
        add_a_c = is_div_q ? {hi_q, lo_q[WIDTH-1]} : {1'b0, hi_q};
        add_b_c = '0;
        if (is_div_q) begin
            add_b_c = ~{1'b0, opnd_q};
        end else if (lo_q[0]) begin
            add_b_c = {1'b0, opnd_q};
        end
        sum_c       = {1'b0, add_a_c} + {1'b0, add_b_c} + (WIDTH+2)'(is_div_q);
        no_borrow_c = sum_c[WIDTH+1];
        if (is_div_q) begin
            hi_nxt_c = no_borrow_c ? sum_c[WIDTH-1:0] : add_a_c[WIDTH-1:0];
            lo_nxt_c = {lo_q[WIDTH-2:0], no_borrow_c};
        end else begin
            hi_nxt_c = sum_c[WIDTH:1];
            lo_nxt_c = {sum_c[0], lo_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q       <= '0;
            lo_q       <= '0;
            opnd_q     <= '0;
            a_raw_q    <= '0;
            count_q    <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else if (load) begin
            hi_q       <= '0;
            lo_q       <= a_mag_c;
            opnd_q     <= b_mag_c;
            a_raw_q    <= a;
            count_q    <= '0;
            is_div_q   <= is_div;
            neg_q      <= sign && (a[WIDTH-1] ^ b[WIDTH-1]);
            rem_neg_q  <= sign && a[WIDTH-1];
            div_zero_q <= is_div && (b == '0);
        end else if (step) begin
            hi_q    <= hi_nxt_c;
            lo_q    <= lo_nxt_c;
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign last_c = (count_q == CNT_W'(WIDTH-1));

    // Sign fix: negate the full product, or quotient/remainder separately; divide-by-zero overrides.
    always_comb begin
        prod_c   = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        fix_hi_c = prod_c[2*WIDTH-1:WIDTH];
        fix_lo_c = prod_c[WIDTH-1:0];
        if (is_div_q) begin
            fix_lo_c = neg_q ? -lo_q : lo_q;
            fix_hi_c = rem_neg_q ? -hi_q : hi_q;
            if (div_zero_q) begin
                fix_lo_c = '1;
                fix_hi_c = a_raw_q;
            end
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// Registered execute-stage ALU: single-cycle ALUConf ops plus iterative mult/div into HI/LO,
// with a start/busy/done handshake.
module alu_muldiv import alu_pkg::*; #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CONF_W-1:0] ALUConf,
    input  logic              Sign,
    input  logic [WIDTH-1:0]  In1,
    input  logic [WIDTH-1:0]  In2,
    output logic [WIDTH-1:0]  Result,
    output logic              Zero,
    output logic [WIDTH-1:0]  Hi,
    output logic [WIDTH-1:0]  Lo,
    output logic              busy,
    output logic              done
);

    state_t             state_q, state_d;
    logic               load_c, step_c, commit_c, single_c, last_c, slt_c;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   alu_c, fix_hi_c, fix_lo_c;

    assign shamt = In1[SHAMT_W-1:0];
    assign slt_c = Sign ? ($signed(In1) < $signed(In2)) : (In1 < In2);

    // Single-cycle datapath; shifts move In2 by the low bits of In1.
    always_comb begin
        alu_c = '0;
        case (ALUConf)
            ALU_ADD:  alu_c = In1 + In2;
            ALU_OR:   alu_c = In1 | In2;
            ALU_AND:  alu_c = In1 & In2;
            ALU_ANDN: alu_c = In1 & ~In2;
            ALU_SUB:  alu_c = In1 - In2;
            ALU_SLT:  alu_c = WIDTH'(slt_c);
            ALU_NOR:  alu_c = ~(In1 | In2);
            ALU_XOR:  alu_c = In1 ^ In2;
            ALU_SRL:  alu_c = In2 >> shamt;
            ALU_SRA:  alu_c = $unsigned($signed(In2) >>> shamt);
            ALU_SLL:  alu_c = In2 << shamt;
            ALU_MFHI: alu_c = Hi;
            ALU_MFLO: alu_c = Lo;
            default:  alu_c = '0;
        endcase
    end

    // Next-state and control strobes.
    always_comb begin
        state_d  = state_q;
        load_c   = 1'b0;
        step_c   = 1'b0;
        commit_c = 1'b0;
        single_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_iter_op(ALUConf)) begin
                        load_c  = 1'b1;
                        state_d = ST_CALC;
                    end else begin
                        single_c = 1'b1;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_CALC: begin
                step_c = 1'b1;
                if (last_c) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                commit_c = 1'b1;
                state_d  = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d == ST_CALC) || (state_d == ST_FIX);
            done    <= (state_d == ST_DONE);
        end
    end

    // Architectural outputs; HI/LO only move when an iterative op commits.
    always_ff @(posedge clk) begin
        if (reset) begin
            Result <= '0;
            Zero   <= 1'b1;
            Hi     <= '0;
            Lo     <= '0;
        end else if (commit_c) begin
            Hi     <= fix_hi_c;
            Lo     <= fix_lo_c;
            Result <= fix_lo_c;
            Zero   <= (fix_lo_c == '0);
        end else if (single_c) begin
            Result <= alu_c;
            Zero   <= (alu_c == '0);
        end
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .reset    (reset),
        .load     (load_c),
        .step     (step_c),
        .is_div   (ALUConf == ALU_DIV),
        .sign     (Sign),
        .a        (In1),
        .b        (In2),
        .last_c   (last_c),
        .fix_hi_c (fix_hi_c),
        .fix_lo_c (fix_lo_c)
    );

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed vector table, handshake corner cases,
// and randomized ops against an arithmetic reference model at WIDTH=32 and WIDTH=16.
module tb_alu_muldiv;
    import alu_pkg::*;

    logic        clk, reset;
    logic        start, sign, start16, sign16;
    logic [4:0]  conf, conf16;
    logic [31:0] in1, in2, res32, hi32, lo32;
    logic [15:0] in1_16, in2_16, res16, hi16, lo16;
    logic        zero32, busy32, done32, zero16, busy16, done16;

    int checks = 0;
    int errors = 0;

    alu_muldiv #(.WIDTH(32)) u_dut (
        .clk(clk), .reset(reset), .start(start), .ALUConf(conf), .Sign(sign),
        .In1(in1), .In2(in2), .Result(res32), .Zero(zero32), .Hi(hi32), .Lo(lo32),
        .busy(busy32), .done(done32)
    );

    alu_muldiv #(.WIDTH(16)) u_dut16 (
        .clk(clk), .reset(reset), .start(start16), .ALUConf(conf16), .Sign(sign16),
        .In1(in1_16), .In2(in2_16), .Result(res16), .Zero(zero16), .Hi(hi16), .Lo(lo16),
        .busy(busy16), .done(done16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [4:0]  c;
        logic        s;
        logic [31:0] a, b, res, hi, lo;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string n, input logic [4:0] c, input logic s,
                                input logic [31:0] a, b, res, hi, lo);
        vec_t v;
        v.name = n; v.c = c; v.s = s; v.a = a; v.b = b; v.res = res; v.hi = hi; v.lo = lo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic longint sx(input longint unsigned x, input int w);
        longint unsigned m;
        m = (64'd1 << w) - 64'd1;
        if (x[w-1]) return longint'(x | ~m);
        return longint'(x & m);
    endfunction

    // Reference model: plain 64-bit arithmetic on the operation's definition.
    task automatic model(input int w, input logic [4:0] c, input logic s,
                         input logic [31:0] a, b, hi_in, lo_in,
                         output logic [31:0] res, hi_o, lo_o);
        longint unsigned mask, ua, ub;
        longint sa, sb, p, q, r;
        int sh;
        mask = (64'd1 << w) - 64'd1;
        ua = longint'(a) & mask;
        ub = longint'(b) & mask;
        sa = sx(ua, w);
        sb = sx(ub, w);
        sh = int'(ua % longint'(w));
        hi_o = hi_in; lo_o = lo_in; res = '0;
        case (c)
            ALU_ADD:  res = 32'((ua + ub) & mask);
            ALU_OR:   res = 32'(ua | ub);
            ALU_AND:  res = 32'(ua & ub);
            ALU_ANDN: res = 32'(ua & ~ub & mask);
            ALU_SUB:  res = 32'((ua - ub) & mask);
            ALU_SLT:  res = s ? 32'(sa < sb) : 32'(ua < ub);
            ALU_NOR:  res = 32'(~(ua | ub) & mask);
            ALU_XOR:  res = 32'(ua ^ ub);
            ALU_SRL:  res = 32'(ub >> sh);
            ALU_SRA:  res = 32'((sb >>> sh) & mask);
            ALU_SLL:  res = 32'((ub << sh) & mask);
            ALU_MFHI: res = hi_in;
            ALU_MFLO: res = lo_in;
            ALU_MULT: begin
                p = s ? sa * sb : longint'(ua * ub);
                hi_o = 32'((p >> w) & mask);
                lo_o = 32'(p & mask);
                res  = lo_o;
            end
            ALU_DIV: begin
                if (ub == 0) begin
                    lo_o = 32'(mask);
                    hi_o = 32'(ua);
                end else begin
                    if (s) begin q = sa / sb; r = sa % sb; end
                    else   begin q = longint'(ua / ub); r = longint'(ua % ub); end
                    lo_o = 32'(q & mask);
                    hi_o = 32'(r & mask);
                end
                res = lo_o;
            end
            default: res = '0;
        endcase
    endtask

    // Issue one op, optionally pulse a stray start at cycle 'glitch', and wait (bounded) for done.
    task automatic run_op(input int w, input logic [4:0] c, input logic s,
                          input logic [31:0] a, b, input int glitch,
                          output logic [31:0] res, hi, lo, output logic zero,
                          output int lat, output logic busy_ok);
        logic iter, d, bz;
        iter = (c == ALU_MULT) || (c == ALU_DIV);
        @(negedge clk);
        if (w == 32) begin start = 1'b1; conf = c; sign = s; in1 = a; in2 = b; end
        else begin start16 = 1'b1; conf16 = c; sign16 = s; in1_16 = a[15:0]; in2_16 = b[15:0]; end
        @(posedge clk); #1;
        start = 1'b0; start16 = 1'b0;
        in1 = $urandom; in2 = $urandom; conf = 5'($urandom); sign = 1'($urandom);
        in1_16 = 16'($urandom); in2_16 = 16'($urandom); conf16 = 5'($urandom);
        lat = 1; busy_ok = 1'b1;
        while (lat < 100) begin
            d  = (w == 32) ? done32 : done16;
            bz = (w == 32) ? busy32 : busy16;
            if (d) break;
            if (bz !== iter) busy_ok = 1'b0;
            if (lat == glitch) begin
                if (w == 32) begin start = 1'b1; conf = ALU_ADD; in1 = 32'd1; in2 = 32'd1; end
                else begin start16 = 1'b1; conf16 = ALU_ADD; in1_16 = 16'd1; in2_16 = 16'd1; end
            end
            @(posedge clk); #1;
            start = 1'b0; start16 = 1'b0;
            lat++;
        end
        if (((w == 32) ? busy32 : busy16) !== 1'b0) busy_ok = 1'b0;
        if (w == 32) begin res = res32; hi = hi32; lo = lo32; zero = zero32; end
        else begin res = {16'd0, res16}; hi = {16'd0, hi16}; lo = {16'd0, lo16}; zero = zero16; end
        @(posedge clk); #1;
    endtask

    task automatic check_op(input string n, input int w, input logic [4:0] c,
                            input logic [31:0] res, hi, lo, input logic zero, input int lat,
                            input logic busy_ok, input logic [31:0] e_res, e_hi, e_lo);
        int e_lat;
        e_lat = ((c == ALU_MULT) || (c == ALU_DIV)) ? w + 2 : 1;
        chk({n, "_result"}, res, e_res);
        chk({n, "_zero"}, 32'(zero), 32'(e_res == 32'd0));
        chk({n, "_hi"}, hi, e_hi);
        chk({n, "_lo"}, lo, e_lo);
        chk({n, "_latency"}, 32'(lat), 32'(e_lat));
        chk({n, "_busy"}, 32'(busy_ok), 32'd1);
    endtask

    initial begin
        logic [31:0] r, h, l, er, eh, el, mh, ml, a, b;
        logic        z, bok, s, seen_done;
        logic [4:0]  c;
        int          lat;
        logic [4:0]  ops[16];

        ops = '{ALU_ADD, ALU_OR, ALU_AND, ALU_ANDN, ALU_SUB, ALU_SLT, ALU_NOR, ALU_XOR,
                ALU_SRL, ALU_SRA, ALU_SLL, ALU_MFHI, ALU_MFLO, ALU_MULT, ALU_DIV, 5'b00100};

        vecs.push_back(mk("add_wrap", ALU_ADD,  0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 0));
        vecs.push_back(mk("sub_zero", ALU_SUB,  0, 32'd5, 32'd5, 32'h0, 0, 0));
        vecs.push_back(mk("slt_s",    ALU_SLT,  1, 32'hFFFFFFFF, 32'h1, 32'h1, 0, 0));
        vecs.push_back(mk("slt_u",    ALU_SLT,  0, 32'hFFFFFFFF, 32'h1, 32'h0, 0, 0));
        vecs.push_back(mk("sra",      ALU_SRA,  0, 32'd4, 32'h80000000, 32'hF8000000, 0, 0));
        vecs.push_back(mk("srl",      ALU_SRL,  0, 32'd4, 32'hF0, 32'hF, 0, 0));
        vecs.push_back(mk("sll_mask", ALU_SLL,  0, 32'd36, 32'h1, 32'h10, 0, 0));
        vecs.push_back(mk("nor",      ALU_NOR,  0, 32'h0, 32'h0, 32'hFFFFFFFF, 0, 0));
        vecs.push_back(mk("xor",      ALU_XOR,  0, 32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F, 0, 0));
        vecs.push_back(mk("andn",     ALU_ANDN, 0, 32'hF0F0, 32'h0FF0, 32'hF000, 0, 0));
        vecs.push_back(mk("or",       ALU_OR,   0, 32'hF0, 32'h0F, 32'hFF, 0, 0));
        vecs.push_back(mk("and",      ALU_AND,  0, 32'hF0, 32'h3C, 32'h30, 0, 0));
        vecs.push_back(mk("mult_s",   ALU_MULT, 1, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 32'hFFFFFFFF, 32'hFFFFFFEB));
        vecs.push_back(mk("mult_u",   ALU_MULT, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFE, 32'h1));
        vecs.push_back(mk("div_s",    ALU_DIV,  1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD));
        vecs.push_back(mk("div_min",  ALU_DIV,  1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 32'h80000000));
        vecs.push_back(mk("div_zero", ALU_DIV,  0, 32'd9, 32'd0, 32'hFFFFFFFF, 32'd9, 32'hFFFFFFFF));
        vecs.push_back(mk("mfhi",     ALU_MFHI, 0, 32'h0, 32'h0, 32'd9, 32'd9, 32'hFFFFFFFF));
        vecs.push_back(mk("mflo",     ALU_MFLO, 0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'd9, 32'hFFFFFFFF));
        vecs.push_back(mk("unlisted", 5'b11111, 0, 32'd1, 32'd2, 32'h0, 32'd9, 32'hFFFFFFFF));

        reset = 1'b1; start = 1'b0; start16 = 1'b0; sign = 1'b0; sign16 = 1'b0;
        conf = '0; conf16 = '0; in1 = '0; in2 = '0; in1_16 = '0; in2_16 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", res32, 32'h0);
        chk("rst_zero", 32'(zero32), 32'd1);
        chk("rst_hi", hi32, 32'h0);
        chk("rst_lo", lo32, 32'h0);
        chk("rst_busy", 32'(busy32), 32'd0);
        chk("rst_done", 32'(done32), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            run_op(32, vecs[i].c, vecs[i].s, vecs[i].a, vecs[i].b, -1, r, h, l, z, lat, bok);
            check_op(vecs[i].name, 32, vecs[i].c, r, h, l, z, lat, bok, vecs[i].res, vecs[i].hi, vecs[i].lo);
        end

        // Stray start while busy (early CALC and in FIX) must not disturb the running op.
        run_op(32, ALU_MULT, 1, 32'd6, 32'd7, 3, r, h, l, z, lat, bok);
        check_op("glitch_mult", 32, ALU_MULT, r, h, l, z, lat, bok, 32'd42, 32'd0, 32'd42);
        run_op(32, ALU_DIV, 0, 32'd100, 32'd7, 33, r, h, l, z, lat, bok);
        check_op("glitch_div", 32, ALU_DIV, r, h, l, z, lat, bok, 32'd14, 32'd2, 32'd14);
        run_op(32, ALU_MFHI, 0, 32'd0, 32'd0, -1, r, h, l, z, lat, bok);
        check_op("mfhi_new", 32, ALU_MFHI, r, h, l, z, lat, bok, 32'd2, 32'd2, 32'd14);
        run_op(32, ALU_MFLO, 0, 32'd0, 32'd0, -1, r, h, l, z, lat, bok);
        check_op("mflo_new", 32, ALU_MFLO, r, h, l, z, lat, bok, 32'd14, 32'd2, 32'd14);

        // Reset in the middle of a divide aborts it and clears HI/LO.
        @(negedge clk);
        start = 1'b1; conf = ALU_DIV; sign = 1'b0; in1 = 32'd1000; in2 = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", 32'(busy32), 32'd0);
        chk("abort_done", 32'(done32), 32'd0);
        chk("abort_hi", hi32, 32'h0);
        chk("abort_lo", lo32, 32'h0);
        chk("abort_result", res32, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done32 || busy32) seen_done = 1'b1;
        end
        chk("abort_no_done", 32'(seen_done), 32'd0);

        mh = '0; ml = '0;
        for (int i = 0; i < 150; i++) begin
            c = ops[$urandom_range(0, 15)]; s = 1'($urandom); a = $urandom; b = $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'h0;
            else if ($urandom_range(0, 7) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            model(32, c, s, a, b, mh, ml, er, eh, el);
            run_op(32, c, s, a, b, -1, r, h, l, z, lat, bok);
            check_op($sformatf("rnd32_%0d_op%b", i, c), 32, c, r, h, l, z, lat, bok, er, eh, el);
            mh = eh; ml = el;
        end

        mh = '0; ml = '0;
        for (int i = 0; i < 60; i++) begin
            c = ops[$urandom_range(0, 15)]; s = 1'($urandom);
            a = {16'd0, 16'($urandom)}; b = {16'd0, 16'($urandom)};
            if ($urandom_range(0, 7) == 0) b = 32'h0;
            else if ($urandom_range(0, 7) == 0) begin a = 32'h8000; b = 32'hFFFF; end
            model(16, c, s, a, b, mh, ml, er, eh, el);
            run_op(16, c, s, a, b, -1, r, h, l, z, lat, bok);
            check_op($sformatf("rnd16_%0d_op%b", i, c), 16, c, r, h, l, z, lat, bok, er, eh, el);
            mh = eh; ml = el;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised, registered successor to the CPU's combinational ALU. Executes the existing ALUConf operations with a one-cycle registered latency and adds iterative multiply/divide into architectural HI/LO registers, using a start/busy/done handshake. Sits in the execute stage of the multi-cycle CPU; the controller holds the datapath while `busy` is high.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width (≥ 8, power of two)
- `SHAMT_W`, $clog2(WIDTH), shift-amount width (derived, do not override)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- `start`  in  1  request; sampled only in IDLE
- `ALUConf`  in  5  operation select, captured with `start`
- `Sign`  in  1  signed mode for SLT/MULT/DIV, captured with `start`
- `In1`, `In2`  in  WIDTH  operands, captured with `start`
- `Result`  out  WIDTH  registered result, held until next completion
- `Zero`  out  1  registered, `Result == 0`
- `Hi`, `Lo`  out  WIDTH  HI/LO architectural registers
- `busy`  out  1  high in CALC and FIX
- `done`  out  1  one-cycle pulse, state DONE

## Operation
- Single-cycle ops (ALUConf): 00000 add, 00001 or, 00010 and, 00011 In1 & ~In2, 00110 sub, 00111 slt (signed if `Sign`, else unsigned; result zero-extended 0/1), 01100 nor, 01101 xor, 10000 srl In2 by In1[SHAMT_W-1:0], 11000 sra, 11001 sll, 10110 mfhi (Result=Hi), 10111 mflo (Result=Lo). Unlisted codes: Result=0, Hi/Lo unchanged.
- Iterative ops: 10100 mult, 10101 div. Add/sub wrap modulo 2^WIDTH, no overflow flag.
- mult: 2·WIDTH product; Hi = upper half, Lo = lower half. Signed: multiply magnitudes, negate 2·WIDTH product if operand signs differ.
- div: Lo = quotient, Hi = remainder, truncation toward zero; remainder takes dividend sign. Restoring division on magnitudes.
- Divide by zero: Lo = all ones, Hi = In1; no exception.
- Signed MIN / -1: Lo = MIN, Hi = 0.
- After mult/div, Result = new Lo.
- FSM: IDLE → (start, single-cycle op) DONE; IDLE → (start, mult/div) CALC; CALC (WIDTH iterations, one bit/cycle) → FIX (sign correction, write Hi/Lo) → DONE → IDLE.
- `start` ignored in CALC, FIX, DONE; operands must not be assumed held after capture.

## Timing
- Reset: state IDLE, Result=0, Zero=1, Hi=0, Lo=0, busy=0, done=0. Reset mid-operation aborts; Hi/Lo cleared, no done pulse.
- Single-cycle op: start at edge N → Result/Zero valid and done=1 during cycle N+1.
- mult/div: start at edge N → busy=1 cycles N+1..N+WIDTH+1 → done=1 and Hi/Lo/Result valid cycle N+WIDTH+2 (WIDTH=32: 34 cycles).
- Earliest next accept: edge after DONE (back-to-back issue every 2 cycles for single-cycle ops).
- Hi/Lo change only on FIX-to-DONE edge or reset; mfhi/mflo after done sees the new values.

## Structure
- Package `alu_pkg`: ALUConf localparams (names per op), FSM state enum {IDLE, CALC, FIX, DONE}.
- Sub-module `muldiv_iter`: iterative shift-add multiplier and restoring divider sharing one WIDTH+1 adder, count register, and sign-fix logic; top holds FSM control, single-cycle ALU logic, Result/Hi/Lo registers.

## Test plan
- Reset, then add 0x7FFFFFFF+1 → done at cycle 1, Result=0x80000000, Zero=0; sub 5-5 → Result=0, Zero=1.
- slt 0xFFFFFFFF vs 1: Sign=1 → Result=1; Sign=0 → Result=0; sra 0x80000000 by 4 → 0xF8000000.
- mult signed -3 × 7 → done at cycle 34, Hi=0xFFFFFFFF, Lo=0xFFFFFFEB, Result=Lo; unsigned 0xFFFFFFFF² → Hi=0xFFFFFFFE, Lo=1.
- div signed -7/2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; 0x80000000/-1 → Lo=0x80000000, Hi=0; x/0 with In1=9 → Lo=0xFFFFFFFF, Hi=9.
- start pulsed while busy with different op → ignored, original result delivered; then mfhi/mflo return new Hi/Lo.
- reset asserted mid-div → next cycle IDLE, busy=0, Hi=Lo=0, no done; WIDTH=16 build repeats mult/div checks with 18-cycle latency.
